// File: rtl/text_ram_writer.sv
// Byte-stream feeder for the character-cell text RAM. Owns the RAM's address/write
// port, passing the display's scan address through and writing only during blanking.
module text_ram_writer #(
  parameter int          ROW_BITS = 5,
  parameter int          COL_BITS = 5,
  parameter logic [7:0]  FILL     = 8'h00
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         display_on,
  input  logic [ROW_BITS+COL_BITS-1:0] disp_addr,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [ROW_BITS+COL_BITS-1:0] ram_addr,
  output logic [7:0]                   ram_din,
  output logic                         ram_we,
  output logic [ROW_BITS+COL_BITS-1:0] cursor,
  output logic                         busy
);

  localparam int A = ROW_BITS + COL_BITS;
  localparam logic [A-1:0]        ADDR_ONE = A'(1);
  localparam logic [ROW_BITS-1:0] ROW_ONE  = ROW_BITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [A-1:0] cursor_q, cursor_d;
  logic [A-1:0] clr_addr_q, clr_addr_d;
  logic [7:0]   byte_q, byte_d;
  logic [A-1:0] wr_addr;
  logic         accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cursor_q   <= '0;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Latched character carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk) begin
    byte_q <= byte_d;
  end

  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    clr_addr_d = clr_addr_q;
    byte_d     = byte_q;
    accept     = (state_q == ST_IDLE) && in_valid;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!in_data[7]) begin
            byte_d  = in_data;
            state_d = ST_WRITE;
          end else if (in_data == 8'h80) begin
            clr_addr_d = '0;
            state_d    = ST_CLEAR;
          end else if (in_data == 8'h81) begin
            cursor_d = '0;
          end else if (in_data == 8'h82) begin
            cursor_d = {cursor_q[A-1:COL_BITS] + ROW_ONE, {COL_BITS{1'b0}}};
          end
        end
      end
      ST_WRITE: begin
        if (!display_on) begin
          cursor_d = cursor_q + ADDR_ONE;
          state_d  = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // Suspended, not restarted, while the display owns the RAM.
        if (!display_on) begin
          clr_addr_d = clr_addr_q + ADDR_ONE;
          if (clr_addr_q == {A{1'b1}}) begin
            cursor_d = '0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Port mux: display always wins, writes only land in blanking cycles.
  always_comb begin
    wr_addr  = (state_q == ST_CLEAR) ? clr_addr_q : cursor_q;
    ram_addr = display_on ? disp_addr : wr_addr;
    ram_din  = (state_q == ST_CLEAR) ? FILL : byte_q;
    ram_we   = !display_on && (state_q != ST_IDLE);
    in_ready = (state_q == ST_IDLE);
    busy     = (state_q != ST_IDLE);
    cursor   = cursor_q;
  end

endmodule

// File: tb/tb_text_ram_writer.sv
// Directed bench for text_ram_writer: writes, blanking hold, cursor wrap and commands,
// interrupted clear, reset abort and ignored bytes.
module tb_text_ram_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       display_on;
  logic [9:0] disp_addr;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [9:0] cursor;
  logic       busy;

  int total = 0;
  int bad   = 0;

  text_ram_writer #(.ROW_BITS(5), .COL_BITS(5), .FILL(8'h00)) dut (
    .clk(clk), .reset(reset), .display_on(display_on), .disp_addr(disp_addr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .cursor(cursor), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled only around the falling edge.
  task automatic offer(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    offer(b);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    total++; if (cursor !== 10'd0) begin bad++; $display("FAIL reset_cursor got=%0d want=0", cursor); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", ram_we); end
  endtask

  task automatic test_write;
    offer(8'h05);
    total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL wr_we got=%b want=1", ram_we); end
    total++; if (ram_addr !== 10'd0) begin bad++; $display("FAIL wr_addr got=%0d want=0", ram_addr); end
    total++; if (ram_din !== 8'h05) begin bad++; $display("FAIL wr_din got=%h want=05", ram_din); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL wr_ready_busy got=%b want=0", in_ready); end
    @(negedge clk); #1;
    total++; if (cursor !== 10'd1) begin bad++; $display("FAIL wr_cursor got=%0d want=1", cursor); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL wr_ready_after got=%b want=1", in_ready); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL wr_we_after got=%b want=0", ram_we); end
  endtask

  task automatic test_display_hold;
    int we_seen = 0;
    int mux_err = 0;
    write_byte(8'h10);
    write_byte(8'h11);
    total++; if (cursor !== 10'd3) begin bad++; $display("FAIL hold_start_cursor got=%0d want=3", cursor); end
    display_on = 1'b1;
    disp_addr  = 10'd700;
    offer(8'h07);
    for (int i = 0; i < 20; i++) begin
      disp_addr = 10'(i * 37 + 5);
      #1;
      if (ram_we !== 1'b0) we_seen++;
      if (ram_addr !== disp_addr) mux_err++;
      @(negedge clk);
    end
    total++; if (we_seen !== 0) begin bad++; $display("FAIL hold_no_we got=%0d want=0", we_seen); end
    total++; if (mux_err !== 0) begin bad++; $display("FAIL hold_addr_mux got=%0d want=0", mux_err); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b want=1", busy); end
    display_on = 1'b0;
    #1;
    total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL hold_release_we got=%b want=1", ram_we); end
    total++; if (ram_addr !== 10'd3) begin bad++; $display("FAIL hold_release_addr got=%0d want=3", ram_addr); end
    total++; if (ram_din !== 8'h07) begin bad++; $display("FAIL hold_release_din got=%h want=07", ram_din); end
    @(negedge clk); #1;
    total++; if (cursor !== 10'd4) begin bad++; $display("FAIL hold_cursor got=%0d want=4", cursor); end
  endtask

  task automatic test_wrap_and_cmds;
    do_reset();
    for (int i = 0; i < 31; i++) offer(8'h82);
    total++; if (cursor !== 10'd992) begin bad++; $display("FAIL nl31_cursor got=%0d want=992", cursor); end
    for (int i = 0; i < 31; i++) write_byte(8'h41);
    total++; if (cursor !== 10'd1023) begin bad++; $display("FAIL pre_wrap_cursor got=%0d want=1023", cursor); end
    offer(8'h01);
    total++; if (ram_we !== 1'b1 || ram_addr !== 10'd1023) begin bad++; $display("FAIL wrap_write got=we%b/%0d want=we1/1023", ram_we, ram_addr); end
    @(negedge clk); #1;
    total++; if (cursor !== 10'd0) begin bad++; $display("FAIL wrap_cursor got=%0d want=0", cursor); end
    offer(8'h82);
    for (int i = 0; i < 5; i++) write_byte(8'h42);
    total++; if (cursor !== 10'd37) begin bad++; $display("FAIL pre_nl_cursor got=%0d want=37", cursor); end
    offer(8'h82);
    total++; if (cursor !== 10'd64) begin bad++; $display("FAIL nl_cursor got=%0d want=64", cursor); end
    total++; if (ram_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL nl_idle got=we%b busy%b want=we0 busy0", ram_we, busy); end
    offer(8'h81);
    total++; if (cursor !== 10'd0) begin bad++; $display("FAIL home_cursor got=%0d want=0", cursor); end
    total++; if (ram_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL home_idle got=we%b busy%b want=we0 busy0", ram_we, busy); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] we_pat;
    in_valid = 1'b1;
    in_data  = 8'h20;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) in_valid = 1'b0;
      #1;
      we_pat[i] = ram_we;
    end
    total++; if (we_pat !== 4'b0101) begin bad++; $display("FAIL b2b_we_pattern got=%b want=0101", we_pat); end
    total++; if (cursor !== 10'd2) begin bad++; $display("FAIL b2b_cursor got=%0d want=2", cursor); end
  endtask

  task automatic test_ignore;
    offer(8'hC4);
    total++; if (busy !== 1'b0 || ram_we !== 1'b0) begin bad++; $display("FAIL ignore_idle got=busy%b we%b want=0/0", busy, ram_we); end
    total++; if (cursor !== 10'd2) begin bad++; $display("FAIL ignore_cursor got=%0d want=2", cursor); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ignore_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_clear;
    int n_we = 0;
    int addr_err = 0;
    int din_err = 0;
    int ctl_err = 0;
    int cyc = 0;
    logic [9:0] exp_addr = 10'd0;
    logic done = 1'b0;
    disp_addr = 10'd999;
    offer(8'h80);
    while (!done && cyc < 4000) begin
      display_on = ((cyc / 100) % 2) == 1;
      #1;
      if (!busy) begin
        done = 1'b1;
      end else begin
        if (in_ready !== 1'b0) ctl_err++;
        if (display_on && ram_we) ctl_err++;
        if (ram_we) begin
          if (ram_addr !== exp_addr) addr_err++;
          if (ram_din !== 8'h00) din_err++;
          exp_addr = exp_addr + 10'd1;
          n_we++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    display_on = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL clear_timeout got=%0d cycles want=completion", cyc); end
    total++; if (n_we !== 1024) begin bad++; $display("FAIL clear_we_count got=%0d want=1024", n_we); end
    total++; if (addr_err !== 0) begin bad++; $display("FAIL clear_addr_order got=%0d errors want=0", addr_err); end
    total++; if (din_err !== 0) begin bad++; $display("FAIL clear_data got=%0d errors want=0", din_err); end
    total++; if (ctl_err !== 0) begin bad++; $display("FAIL clear_ctl got=%0d errors want=0", ctl_err); end
    total++; if (cursor !== 10'd0) begin bad++; $display("FAIL clear_cursor got=%0d want=0", cursor); end
  endtask

  task automatic test_reset_mid_clear;
    write_byte(8'h33);
    write_byte(8'h34);
    offer(8'h80);
    for (int i = 0; i < 500; i++) @(negedge clk);
    #1;
    total++; if (ram_addr !== 10'd500 || ram_we !== 1'b1) begin bad++; $display("FAIL midclear_addr got=%0d we%b want=500 we1", ram_addr, ram_we); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || ram_we !== 1'b0) begin bad++; $display("FAIL abort_idle got=busy%b we%b want=0/0", busy, ram_we); end
    total++; if (cursor !== 10'd0) begin bad++; $display("FAIL abort_cursor got=%0d want=0", cursor); end
    offer(8'h09);
    total++; if (ram_we !== 1'b1 || ram_addr !== 10'd0 || ram_din !== 8'h09) begin bad++; $display("FAIL post_abort_write got=we%b/%0d/%h want=we1/0/09", ram_we, ram_addr, ram_din); end
  endtask

  initial begin
    reset      = 1'b1;
    display_on = 1'b0;
    disp_addr  = 10'd0;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    test_reset();
    test_write();
    test_display_hold();
    test_wrap_and_cmds();
    test_back_to_back();
    test_ignore();
    test_clear();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
